// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: scoreboard slot layout and
// the hazard cause encoding exported for debug.
package pipe_hazard_ctrl_pkg;

   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       regw;
      logic       load;
   } slot_t;

   typedef enum logic [1:0] {
      HAZ_NONE     = 2'd0,
      LOAD_USE     = 2'd1,
      BR_EX        = 2'd2,
      BR_MEM_LD    = 2'd3
   } haz_e;

   localparam slot_t SlotBubble = '0;

   // $0 is hardwired to zero, so a write to it can never feed a consumer.
   function automatic logic slot_writes(input slot_t s, input logic [4:0] r);
      return s.v && s.regw && (s.rd != 5'd0) && (s.rd == r);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard query and the resulting stage-register controls.
interface pipe_hazard_ctrl_if
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
);
   logic             ext_hold;
   logic             id_valid;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [4:0]       id_rd;
   logic             id_regw;
   logic             id_is_load;
   logic             id_is_branch;
   logic             id_take;
   logic             pc_write;
   logic             ifid_write;
   logic             idex_write;
   logic             exmem_write;
   logic             memwb_write;
   logic             ifid_flush;
   logic             idex_flush;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   haz_e             haz_code;

   modport master (
      output ext_hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regw,
             id_is_load, id_is_branch, id_take,
      input  pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush,
             idex_flush, stall_cnt, flush_cnt, haz_code
   );

   modport slave (
      input  ext_hold, id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd, id_regw,
             id_is_load, id_is_branch, id_take,
      output pc_write, ifid_write, idex_write, exmem_write, memwb_write, ifid_flush,
             idex_flush, stall_cnt, flush_cnt, haz_code
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Two-slot (EX, MEM) record of in-flight destinations with per-source match outputs.
module hazard_scoreboard
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       hold_i,
   input  logic       stall_i,
   input  logic       id_valid_i,
   input  logic [4:0] id_rd_i,
   input  logic       id_regw_i,
   input  logic       id_is_load_i,
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_use_rs_i,
   input  logic       id_use_rt_i,
   output logic       ex_hit_o,
   output logic       ex_load_o,
   output logic       mem_ld_hit_o
);

   slot_t ex_q, ex_d;
   slot_t mem_q, mem_d;
   logic  ex_src_hit;
   logic  mem_src_hit;

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      if (!hold_i) begin
         mem_d = ex_q;
         // A stalled ID instruction stays put, so EX receives a bubble.
         ex_d  = stall_i ? SlotBubble
                         : '{v: id_valid_i, rd: id_rd_i, regw: id_regw_i, load: id_is_load_i};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q  <= SlotBubble;
         mem_q <= SlotBubble;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
      end
   end

   always_comb begin
      ex_src_hit  = (id_use_rs_i && slot_writes(ex_q, id_rs_i)) ||
                    (id_use_rt_i && slot_writes(ex_q, id_rt_i));
      mem_src_hit = (id_use_rs_i && slot_writes(mem_q, id_rs_i)) ||
                    (id_use_rt_i && slot_writes(mem_q, id_rt_i));
      ex_hit_o     = ex_src_hit;
      ex_load_o    = ex_q.load;
      mem_ld_hit_o = mem_src_hit && mem_q.load;
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: priority HOLD > STALL > REDIRECT > RUN,
// plus saturating stall and flush event counters.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave bus
);

   logic             ex_hit;
   logic             ex_load;
   logic             mem_ld_hit;
   logic             load_use;
   logic             br_ex;
   logic             br_mem_ld;
   logic             stall;
   logic             redirect;
   logic             all_wr;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   hazard_scoreboard u_scoreboard (
      .clk_i        (clk),
      .rst_i        (rst),
      .hold_i       (bus.ext_hold),
      .stall_i      (stall),
      .id_valid_i   (bus.id_valid),
      .id_rd_i      (bus.id_rd),
      .id_regw_i    (bus.id_regw),
      .id_is_load_i (bus.id_is_load),
      .id_rs_i      (bus.id_rs),
      .id_rt_i      (bus.id_rt),
      .id_use_rs_i  (bus.id_use_rs),
      .id_use_rt_i  (bus.id_use_rt),
      .ex_hit_o     (ex_hit),
      .ex_load_o    (ex_load),
      .mem_ld_hit_o (mem_ld_hit)
   );

   always_comb begin
      load_use  = bus.id_valid && ex_hit && ex_load;
      br_ex     = bus.id_valid && bus.id_is_branch && ex_hit;
      br_mem_ld = bus.id_valid && bus.id_is_branch && mem_ld_hit;
      stall     = load_use || br_ex || br_mem_ld;
      // id_take is only meaningful once the branch operands are available.
      redirect  = bus.id_valid && bus.id_take && !stall;

      if (load_use)       bus.haz_code = LOAD_USE;
      else if (br_ex)     bus.haz_code = BR_EX;
      else if (br_mem_ld) bus.haz_code = BR_MEM_LD;
      else                bus.haz_code = HAZ_NONE;
   end

   always_comb begin
      all_wr          = rst || !bus.ext_hold;
      bus.pc_write    = all_wr;
      bus.ifid_write  = all_wr;
      bus.idex_write  = all_wr;
      bus.exmem_write = all_wr;
      bus.memwb_write = all_wr;
      bus.ifid_flush  = 1'b0;
      bus.idex_flush  = 1'b0;
      if (!rst && !bus.ext_hold) begin
         if (stall) begin
            bus.pc_write   = 1'b0;
            bus.ifid_write = 1'b0;
            bus.idex_flush = 1'b1;
         end else if (redirect) begin
            bus.ifid_flush = 1'b1;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!bus.ext_hold) begin
         if (stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
         if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hand-sequenced MIPS fragments with expected controls.
module tb_pipe_hazard_ctrl;
   localparam int unsigned CNT_W = 16;

   // Control vector order: {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
   localparam logic [6:0] CtlRun   = 7'b1111100;
   localparam logic [6:0] CtlStall = 7'b0011101;
   localparam logic [6:0] CtlRedir = 7'b1111110;
   localparam logic [6:0] CtlHold  = 7'b0000000;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_ctl(input string tag, input logic [6:0] exp);
      logic [6:0] got;
      got = {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write, bus.memwb_write,
             bus.ifid_flush, bus.idex_flush};
      check_eq(tag, {25'd0, got}, {25'd0, exp});
   endtask

   task automatic check_cnt(input string tag, input int stalls, input int flushes);
      check_eq({tag, "_stall_cnt"}, {16'd0, bus.stall_cnt}, stalls);
      check_eq({tag, "_flush_cnt"}, {16'd0, bus.flush_cnt}, flushes);
   endtask

   // valid, rs, rt, use_rs, use_rt, rd, regw, load, branch, take
   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic [4:0] rd,
                         input logic regw, input logic ld, input logic br, input logic take);
      bus.id_valid     = v;
      bus.id_rs        = rs;
      bus.id_rt        = rt;
      bus.id_use_rs    = urs;
      bus.id_use_rt    = urt;
      bus.id_rd        = rd;
      bus.id_regw      = regw;
      bus.id_is_load   = ld;
      bus.id_is_branch = br;
      bus.id_take      = take;
      #1;
   endtask

   task automatic bubble();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic lw8();
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic add9_8_1();
      set_id(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic beq8_0();
      set_id(1'b1, 5'd8, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.ext_hold = 1'b0;
      bubble();
      check_ctl("reset_outputs", CtlRun);
      tick();
      rst = 1'b0;
      #1;
      check_cnt("after_reset", 0, 0);
      check_ctl("after_reset_run", CtlRun);

      // lw $8 ; add $9,$8,$1 -> one load-use stall
      lw8();
      check_ctl("lw_run", CtlRun);
      tick();
      add9_8_1();
      check_ctl("load_use_stall", CtlStall);
      check_eq("load_use_code", {30'd0, bus.haz_code}, 32'd1);
      tick();
      check_ctl("load_use_release", CtlRun);
      check_cnt("load_use", 1, 0);
      tick();

      // lw $8 ; beq $8,$0 taken -> two stalls then redirect
      lw8();
      tick();
      beq8_0();
      check_ctl("br_ld_stall1", CtlStall);
      check_eq("br_ld_code1", {30'd0, bus.haz_code}, 32'd1);
      tick();
      check_ctl("br_ld_stall2", CtlStall);
      check_eq("br_ld_code2", {30'd0, bus.haz_code}, 32'd3);
      tick();
      check_ctl("br_ld_redirect", CtlRedir);
      tick();
      check_cnt("br_ld", 3, 1);
      bubble();
      check_ctl("after_flush_bubble", CtlRun);
      tick();

      // add $8 ; bne $8,$9 taken -> one stall then redirect
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_ctl("br_alu_stall", CtlStall);
      check_eq("br_alu_code", {30'd0, bus.haz_code}, 32'd2);
      tick();
      check_ctl("br_alu_redirect", CtlRedir);
      tick();
      check_cnt("br_alu", 4, 2);
      bubble();
      tick();
      // add $8 ; add $10,$8,$1 -> forwarded, no stall
      set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("alu_fwd_no_stall", CtlRun);
      tick();
      check_cnt("alu_fwd", 4, 2);

      // lw $0 ; add $9,$0,$1 -> $0 never hazards
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      check_ctl("zero_reg_no_stall", CtlRun);
      tick();

      // load-use stall frozen by a 3-cycle hold
      lw8();
      tick();
      add9_8_1();
      bus.ext_hold = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check_ctl($sformatf("hold_ctl_%0d", i), CtlHold);
         tick();
         check_eq($sformatf("hold_stall_cnt_%0d", i), {16'd0, bus.stall_cnt}, 32'd4);
      end
      bus.ext_hold = 1'b0;
      #1;
      check_ctl("post_hold_stall", CtlStall);
      tick();
      check_ctl("post_hold_issue", CtlRun);
      check_cnt("post_hold", 5, 2);
      tick();

      // reset in the middle of a branch-after-load stall
      lw8();
      tick();
      beq8_0();
      tick();
      check_ctl("pre_reset_stall2", CtlStall);
      rst = 1'b1;
      #1;
      check_ctl("reset_mid_stall", CtlRun);
      tick();
      rst = 1'b0;
      #1;
      check_cnt("reset_mid_stall", 0, 0);
      beq8_0();
      check_ctl("after_reset_no_stall", CtlRedir);
      tick();
      bubble();
      tick();

      // counter saturation
      force dut.stall_cnt_q = 16'hFFFF;
      force dut.flush_cnt_q = 16'hFFFF;
      #1;
      release dut.stall_cnt_q;
      release dut.flush_cnt_q;
      lw8();
      tick();
      add9_8_1();
      check_ctl("sat_stall", CtlStall);
      tick();
      check_eq("stall_cnt_saturate", {16'd0, bus.stall_cnt}, 32'h0000FFFF);
      set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_ctl("sat_jump_redirect", CtlRedir);
      tick();
      check_eq("flush_cnt_saturate", {16'd0, bus.flush_cnt}, 32'h0000FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It keeps its own two-entry scoreboard of in-flight destination registers (EX and MEM slots) and compares it with the decoded ID-stage instruction. From that it drives the write enables and flushes of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also counts stall and flush events for performance analysis.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ext_hold  in  1  global freeze request (memory wait, debug)
- id_valid  in  1  ID stage holds a real instruction (not a bubble)
- id_rs, id_rt  in  5 each  ID source register numbers
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt
- id_rd  in  5  ID destination after RegDst selection
- id_regw  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is lw
- id_is_branch  in  1  beq/bne (operands compared in ID)
- id_take  in  1  branch condition true or jump/jal/jr; valid only when id_valid
- pc_write, ifid_write, idex_write, exmem_write, memwb_write  out  1 each  stage register write enables
- ifid_flush  out  1  clear IF/ID on the next edge
- idex_flush  out  1  load a bubble (all controls 0) into ID/EX
- stall_cnt  out  CNT_W  number of cycles with a hazard stall (saturating)
- flush_cnt  out  CNT_W  number of IF/ID flushes (saturating)

## Operation
- Scoreboard slot fields: {v, rd, regw, load}. A slot "writes r" when v=1, regw=1, rd≠0 and rd==r. A destination of $0 never creates a hazard.
- Hazard terms, evaluated on ID sources that are actually used (id_use_*) and only when id_valid:
  - load_use: the EX slot is a load and writes a used source.
  - br_ex: id_is_branch and the EX slot writes a used source (load or ALU).
  - br_mem_ld: id_is_branch and the MEM slot is a load that writes a used source.
- stall = load_use | br_ex | br_mem_ld. ALU results reach ID by forwarding, so non-branch ALU dependencies never stall.
- Per-cycle decision, highest priority first:
  - HOLD (ext_hold=1): all write enables 0, flushes 0, scoreboard and counters frozen.
  - STALL (stall=1): pc_write=ifid_write=0; idex_write=1 with idex_flush=1; exmem_write=memwb_write=1. On the edge the scoreboard shifts with a bubble: MEM←EX, EX←{0,…}. stall_cnt increments.
  - REDIRECT (id_take=1, no stall): all writes 1 and ifid_flush=1. The ID instruction advances, IF/ID is cleared, and flush_cnt increments.
  - RUN: all writes 1, no flush. The scoreboard shifts with MEM←EX and EX←{id_valid, id_rd, id_regw, id_is_load}.
- A branch is never redirected while it is stalled. id_take is ignored until stall=0.
- Counters saturate at all-ones and do not wrap.

## Timing
- All outputs are combinational from the scoreboard and the ID inputs, with no added latency. The scoreboard and counters are registered.
- Stall lengths: load-use is 1 cycle. Branch after an ALU op is 1 cycle. Branch after a load is 2 cycles (first on EX, then on MEM).
- Redirect: exactly one ifid_flush cycle per taken branch or jump.
- Reset (rst=1 at an edge) clears the scoreboard (v=0) and both counters. While rst is high, the outputs are all writes 1, flushes 0. Reset in the middle of a stall abandons it, and the first cycle after reset is RUN.
- When ext_hold and stall are both asserted, the hold wins. The stall is re-evaluated unchanged after the hold drops and is not counted during the hold.

## Structure
- Shared package: slot struct typedef, and a HAZ_NONE/LOAD_USE/BR_EX/BR_MEM_LD encoding for debug visibility.
- Sub-module hazard_scoreboard: holds the two slots, performs the shift/bubble update, and exposes match outputs per source. The top level contains the priority decision and the counters.

## Test plan
- lw $8 followed by add $9,$8,$1: exactly one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_cnt goes 0→1; the add then issues.
- lw $8 followed by beq $8,$0: two consecutive stall cycles, then redirect if taken; stall_cnt=2, flush_cnt=1.
- add $8 followed by bne $8,$9 taken: one stall, then one cycle of ifid_flush=1; non-branch add $10,$8 after add $8 shows no stall.
- lw $0 followed by add $9,$0,$1: no stall; ext_hold raised in the middle of a load-use stall for 3 cycles: all writes 0 and stall_cnt unchanged for those cycles, then one stall cycle.
- rst pulsed during a branch-after-load stall: scoreboard cleared, counters 0, next cycle RUN with all writes 1.
- Preset the counters to 0xFFFF and force further stalls: stall_cnt holds at 0xFFFF.
